// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and constants (receiver and transmitter).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_rx_state_t;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_deser_if.sv
// ============================================================================
// Module      : uart_rx_deser_if
// Description : Received-byte valid/ready handshake plus error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_deser_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] RX_DATA;
    logic                      RX_VALID;
    logic                      RX_READY;
    logic                      FRAME_ERR;
    logic                      OVERRUN;

    modport master (
        output RX_DATA,
        output RX_VALID,
        input  RX_READY,
        output FRAME_ERR,
        output OVERRUN
    );

    modport slave (
        input  RX_DATA,
        input  RX_VALID,
        output RX_READY,
        input  FRAME_ERR,
        input  OVERRUN
    );

endinterface

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : Parameterised-width two-flop synchroniser, resets to all ones.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] i_async,
    output logic      [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx_deser.sv
// ============================================================================
// Module      : uart_rx_deser
// Description : 8N1 UART receiver with centre sampling, one-entry holding
//               register, valid/ready output and framing/overrun pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 500_000_000,
    parameter int BAUD_RATE       = 115_200
) (
    input  wire logic       CLK,
    input  wire logic       NRST,
    input  wire logic       UART_RX_DSER,
    uart_rx_deser_if.master rx
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_cnt_half = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       c_bit_last = 3'(UART_DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_cpb_check
            $error("uart_rx_deser: CLKS_PER_BIT must be at least 4");
        end
    endgenerate

    logic                      w_rx_s;
    uart_rx_state_t            r_state;
    uart_rx_state_t            w_state_next;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          w_cnt_next;
    logic [2:0]                r_bit_idx;
    logic [2:0]                w_bit_next;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] w_shift_next;
    logic                      w_commit;
    logic                      w_frame_err;
    logic                      w_xfer;
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_valid;
    logic                      r_frame_err;
    logic                      r_overrun;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk     (CLK),
        .rst_n   (NRST),
        .i_async (UART_RX_DSER),
        .o_sync  (w_rx_s)
    );

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Every sampling point is reached by counting to a terminal value, so
    // the counter restarts at zero on each sample and on leaving IDLE.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_commit     = 1'b0;
        w_frame_err  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_cnt_next   = '0;
                    w_state_next = START;
                end
            end
            START: begin
                if (r_cnt == c_cnt_half) begin
                    w_cnt_next = '0;
                    if (w_rx_s) begin
                        w_state_next = IDLE;
                    end else begin
                        w_bit_next   = '0;
                        w_state_next = DATA;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            DATA: begin
                if (r_cnt == c_cnt_last) begin
                    w_cnt_next   = '0;
                    w_shift_next = {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
                    if (r_bit_idx == c_bit_last) begin
                        w_state_next = STOP;
                    end else begin
                        w_bit_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            STOP: begin
                if (r_cnt == c_cnt_last) begin
                    w_cnt_next = '0;
                    if (w_rx_s) begin
                        w_commit     = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_frame_err  = 1'b1;
                        w_state_next = WAIT_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (w_rx_s) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_xfer = r_valid && rx.RX_READY;

    // A commit may refill the holding register on the very edge it empties.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_bit_idx   <= w_bit_next;
            r_shift     <= w_shift_next;
            r_frame_err <= w_frame_err;
            r_overrun   <= w_commit && r_valid && !w_xfer;
            if (w_commit && (!r_valid || w_xfer)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx.RX_DATA   = r_data;
    assign rx.RX_VALID  = r_valid;
    assign rx.FRAME_ERR = r_frame_err;
    assign rx.OVERRUN   = r_overrun;

endmodule

`default_nettype wire
